// File: rtl/io_peer_pkg.sv
// rtl/io_peer_pkg.sv - shared state encoding and default sizing for io_peer
package io_peer_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/io_peer_sync_fifo.sv
// rtl/io_peer_sync_fifo.sv - single-clock byte FIFO with pre-edge full/empty
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push, pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_peer.sv
// rtl/io_peer.sv - full-duplex 4-phase handshake responder with host byte FIFOs
module io_peer
  import io_peer_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic [7:0] bus_out,
  input  logic       hs_out,
  output logic [7:0] bus_in,
  output logic       hs_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_underrun,
  output logic       proto_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_ack_q, empty_ack_d;
  logic          tx_underrun_q, tx_underrun_d;
  logic          proto_err_q, proto_err_d;
  logic          rx_push, tx_pop;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (g_clk),
    .rst_n   (g_clr),
    .wr_data (tx_data),
    .wr_en   (tx_valid),
    .full    (tx_full),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (g_clk),
    .rst_n   (g_clr),
    .wr_data (bus_out),
    .wr_en   (rx_push),
    .full    (rx_full),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .empty   (rx_empty)
  );

  assign tx_ready    = ~tx_full;
  assign rx_valid    = ~rx_empty;
  assign hs_in       = (state_q == ACK);
  assign tx_underrun = tx_underrun_q;
  assign proto_err   = proto_err_q;
  // A byte pushed by the host mid-ACK must not appear on bus_in or be consumed
  // by an exchange that started with TX empty.
  assign bus_in      = (state_q == ACK && empty_ack_q) ? 8'h00 : tx_head;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    empty_ack_d   = empty_ack_q;
    tx_underrun_d = tx_underrun_q;
    proto_err_d   = proto_err_q;
    rx_push       = 1'b0;
    tx_pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_out && !rx_full) begin
          rx_push     = 1'b1;
          state_d     = ACK;
          cnt_d       = '0;
          empty_ack_d = tx_empty;
        end
      end
      default: begin
        if (!hs_out) begin
          if (empty_ack_q) tx_underrun_d = 1'b1;
          else             tx_pop        = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          proto_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      empty_ack_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      empty_ack_q   <= empty_ack_d;
      tx_underrun_q <= tx_underrun_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_io_peer.sv
// tb/tb_io_peer.sv - directed self-checking bench for io_peer
module tb_io_peer;

  logic       g_clk = 1'b0;
  logic       g_clr;
  logic [7:0] bus_out;
  logic       hs_out;
  logic [7:0] bus_in;
  logic       hs_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_underrun;
  logic       proto_err;

  int tests = 0;
  int fails = 0;

  io_peer #(.DEPTH(4), .TIMEOUT(255)) dut (
    .g_clk       (g_clk),
    .g_clr       (g_clr),
    .bus_out     (bus_out),
    .hs_out      (hs_out),
    .bus_in      (bus_in),
    .hs_in       (hs_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_underrun (tx_underrun),
    .proto_err   (proto_err)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_clr = 1'b0; bus_out = 8'h00; hs_out = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    #2;
    chk("rst_bus_in", bus_in, 8'h00);
    chk("rst_hs_in", {7'b0, hs_in}, 8'h00);
    chk("rst_tx_ready", {7'b0, tx_ready}, 8'h01);
    chk("rst_rx_valid", {7'b0, rx_valid}, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_flags", {6'b0, tx_underrun, proto_err}, 8'h00);
    @(negedge g_clk);
    g_clr = 1'b1;
    tick();

    // basic exchange
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    bus_out = 8'h3C; hs_out = 1'b1;
    tick();
    chk("s1_hs_in_hi", {7'b0, hs_in}, 8'h01);
    chk("s1_bus_in", bus_in, 8'hA5);
    hs_out = 1'b0;
    tick();
    chk("s1_hs_in_lo", {7'b0, hs_in}, 8'h00);
    chk("s1_rx_data", rx_data, 8'h3C);
    chk("s1_rx_valid", {7'b0, rx_valid}, 8'h01);
    chk("s1_tx_ready", {7'b0, tx_ready}, 8'h01);
    chk("s1_bus_in_after", bus_in, 8'h00);
    chk("s1_no_underrun", {7'b0, tx_underrun}, 8'h00);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("s1_rx_drained", {7'b0, rx_valid}, 8'h00);

    // exchange with empty TX
    bus_out = 8'h11; hs_out = 1'b1;
    tick();
    chk("s2_hs_in_hi", {7'b0, hs_in}, 8'h01);
    chk("s2_bus_in_zero", bus_in, 8'h00);
    chk("s2_underrun_pre", {7'b0, tx_underrun}, 8'h00);
    hs_out = 1'b0;
    tick();
    chk("s2_hs_in_lo", {7'b0, hs_in}, 8'h00);
    chk("s2_underrun", {7'b0, tx_underrun}, 8'h01);
    chk("s2_rx_data", rx_data, 8'h11);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // RX full stalls the processor
    for (int i = 1; i <= 4; i++) begin
      bus_out = 8'(i); hs_out = 1'b1;
      tick();
      hs_out = 1'b0;
      tick();
    end
    bus_out = 8'h05; hs_out = 1'b1;
    tick();
    chk("s3_stall_1", {7'b0, hs_in}, 8'h00);
    tick();
    chk("s3_stall_2", {7'b0, hs_in}, 8'h00);
    chk("s3_rx_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("s3_still_stalled", {7'b0, hs_in}, 8'h00);
    tick();
    chk("s3_accept", {7'b0, hs_in}, 8'h01);
    hs_out = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("s3_drain_%0d", i), rx_data, 8'(i));
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("s3_rx_empty", {7'b0, rx_valid}, 8'h00);

    // simultaneous host and peer push/pop at occupancy 2
    for (int i = 0; i < 2; i++) begin
      bus_out = 8'hC1 + 8'(i); hs_out = 1'b1;
      tick();
      hs_out = 1'b0;
      tick();
    end
    tx_valid = 1'b1; tx_data = 8'hB1;
    tick();
    tx_data = 8'hB2;
    tick();
    tx_valid = 1'b0;
    bus_out = 8'hC3; hs_out = 1'b1; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("s5_ack", {7'b0, hs_in}, 8'h01);
    chk("s5_bus_in_b1", bus_in, 8'hB1);
    chk("s5_rx_head", rx_data, 8'hC2);
    hs_out = 1'b0; tx_valid = 1'b1; tx_data = 8'hB3;
    tick();
    tx_valid = 1'b0;
    chk("s5_idle", {7'b0, hs_in}, 8'h00);
    chk("s5_bus_in_b2", bus_in, 8'hB2);
    chk("s5_rx_c2", rx_data, 8'hC2);
    rx_ready = 1'b1;
    tick();
    chk("s5_rx_c3", rx_data, 8'hC3);
    tick();
    rx_ready = 1'b0;
    chk("s5_rx_count2", {7'b0, rx_valid}, 8'h00);
    for (int i = 0; i < 2; i++) begin
      bus_out = 8'hD1 + 8'(i); hs_out = 1'b1;
      tick();
      chk($sformatf("s5_tx_order_%0d", i), bus_in, 8'hB2 + 8'(i));
      hs_out = 1'b0;
      tick();
    end
    chk("s5_tx_count2", bus_in, 8'h00);
    rx_ready = 1'b1;
    tick();
    tick();
    rx_ready = 1'b0;

    // protocol timeout
    bus_out = 8'hE1; hs_out = 1'b1;
    tick();
    chk("s4_ack", {7'b0, hs_in}, 8'h01);
    for (int i = 0; i < 255; i++) tick();
    chk("s4_err_not_yet", {7'b0, proto_err}, 8'h00);
    tick();
    chk("s4_err_set", {7'b0, proto_err}, 8'h01);
    chk("s4_hs_in_held", {7'b0, hs_in}, 8'h01);
    tick();
    chk("s4_hs_in_held2", {7'b0, hs_in}, 8'h01);
    hs_out = 1'b0;
    tick();
    chk("s4_hs_in_lo", {7'b0, hs_in}, 8'h00);
    chk("s4_err_sticky", {7'b0, proto_err}, 8'h01);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // reset during ACK
    bus_out = 8'hF1; hs_out = 1'b1;
    tick();
    chk("s6_ack", {7'b0, hs_in}, 8'h01);
    chk("s6_rx_valid_pre", {7'b0, rx_valid}, 8'h01);
    #2;
    g_clr = 1'b0;
    #1;
    chk("s6_hs_in_drop", {7'b0, hs_in}, 8'h00);
    chk("s6_rx_valid", {7'b0, rx_valid}, 8'h00);
    chk("s6_flags", {6'b0, tx_underrun, proto_err}, 8'h00);
    #1;
    g_clr = 1'b1;
    tick();
    chk("s6_first_xfer", {7'b0, hs_in}, 8'h01);
    hs_out = 1'b0;
    tick();
    chk("s6_rx_data", rx_data, 8'hF1);
    chk("s6_underrun_after", {7'b0, tx_underrun}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_peer.md
IO_PEER -- requirements
Module: io_peer

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of entries in each byte FIFO (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 255, sets the number of cycles in ACK before a protocol error is flagged.
REQ-003 g_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 g_clr  input  1  reset; asynchronous assertion, active-low.
REQ-005 bus_out  input  8  byte driven by the processor's output register.
REQ-006 hs_out  input  1  processor handshake request.
REQ-007 bus_in  output  8  byte presented to the processor's input register.
REQ-008 hs_in  output  1  peer handshake acknowledge; registered.
REQ-009 tx_data  input  8  host byte to be sent to the processor.
REQ-010 tx_valid  input  1  host offers tx_data.
REQ-011 tx_ready  output  1  TX FIFO not full.
REQ-012 rx_data  output  8  oldest byte received from the processor.
REQ-013 rx_valid  output  1  RX FIFO not empty.
REQ-014 rx_ready  input  1  host accepts rx_data.
REQ-015 tx_underrun  output  1  sticky flag: an exchange completed while the TX FIFO was empty.
REQ-016 proto_err  output  1  sticky flag: hs_out held high for more than TIMEOUT cycles in ACK.

Function
REQ-017 The block is the full-duplex 4-phase responder: each handshake moves one byte processor->peer (bus_out) and one byte peer->processor (bus_in).
REQ-018 The FSM has two states, IDLE (hs_in=0) and ACK (hs_in=1).
REQ-019 In IDLE, with hs_out=1 and the RX FIFO not full, the FSM pushes bus_out into RX, enters ACK, and drives hs_in=1 starting the next cycle.
REQ-020 In IDLE, with hs_out=1 and the RX FIFO full, the FSM stays in IDLE and pushes nothing; the processor stalls.
REQ-021 In ACK, with hs_out=0, the FSM pops the TX FIFO if it is non-empty (otherwise it sets tx_underrun), drives hs_in=0, and returns to IDLE.
REQ-022 bus_in is the TX FIFO head while TX is non-empty, and 8'h00 while it is empty.
REQ-023 bus_in is stable throughout ACK and changes only after the pop.
REQ-024 The ACK cycle counter clears on entry to ACK and saturates at TIMEOUT.
REQ-025 proto_err sets when hs_out=1 and the counter equals TIMEOUT; the FSM remains in ACK until hs_out falls.
REQ-026 A host push occurs when tx_valid&tx_ready; a host pop occurs when rx_valid&rx_ready.
REQ-027 Full and empty are evaluated on the pre-edge occupancy count.
REQ-028 A simultaneous push and pop on a FIFO that is neither full nor empty leaves its occupancy unchanged.
REQ-029 FIFO pointers wrap modulo DEPTH, and the count width is clog2(DEPTH)+1.
REQ-030 A new request may be accepted in the first IDLE cycle after hs_in falls; minimum hs_in low time is one cycle.
REQ-031 Sticky flags clear only on reset.

Reset
REQ-032 While g_clr=0, asynchronously: state=IDLE, hs_in=0, both FIFOs empty, counter=0, tx_underrun=0, proto_err=0.
REQ-033 The resulting outputs during reset are bus_in=8'h00, tx_ready=1, rx_valid=0, and rx_data=8'h00.
REQ-034 Reset asserted mid-handshake drops hs_in immediately and discards the in-flight byte.
REQ-035 The first transfer after reset release occurs only from IDLE.

Structure
REQ-036 A shared package holds the state enum (IDLE, ACK) and the default DEPTH and TIMEOUT constants.
REQ-037 One sub-module, sync_fifo (8-bit, DEPTH-parameterised, with the same clock and reset), is instantiated twice, for TX and RX.

Verification
REQ-038 Scenario: push 8'hA5 to TX; processor drives bus_out=8'h3C and hs_out=1 -> next cycle hs_in=1, bus_in=8'hA5; hs_out=0 -> next cycle hs_in=0, rx_data=8'h3C, rx_valid=1, tx_ready=1.
REQ-039 Scenario: TX empty, one exchange -> bus_in=8'h00 during ACK and tx_underrun=1 afterwards.
REQ-040 Scenario: DEPTH=4, four exchanges with no host pop, then a fifth hs_out=1 -> hs_in stays 0; one host pop -> hs_in=1 on the following cycle.
REQ-041 Scenario: hold hs_out=1 for TIMEOUT+2 cycles in ACK -> proto_err=1 and hs_in stays 1 until hs_out falls.
REQ-042 Scenario: g_clr=0 asserted during ACK -> hs_in=0 in the same cycle, rx_valid=0, and the FSM is in IDLE.
REQ-043 Scenario: host push and pop in the same cycle as a peer push and pop, with occupancy 2 -> occupancy stays 2 and byte order is preserved.
